// File: rtl/usb_uart_stream_bridge.sv
// USB <-> core byte-stream bridge: RX and TX show-ahead FIFOs with a
// runtime loopback/bridge switch, optional drop-on-overflow and flush.

module usb_uart_stream_bridge_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  pop,
  output logic [DATA_W-1:0]     rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Storage is not reset; the read side is masked by empty upstream.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

module usb_uart_stream_bridge #(
  parameter int DATA_W        = 8,
  parameter int DEPTH_LOG2    = 4,
  parameter bit OVERFLOW_DROP = 1'b0,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mode,
  input  logic                flush,
  input  logic [DATA_W-1:0]   usb_rx_data,
  input  logic                usb_rx_valid,
  output logic                usb_rx_ready,
  output logic [DATA_W-1:0]   usb_tx_data,
  output logic                usb_tx_valid,
  input  logic                usb_tx_ready,
  output logic [DATA_W-1:0]   core_rx_data,
  output logic                core_rx_valid,
  input  logic                core_rx_ready,
  input  logic [DATA_W-1:0]   core_tx_data,
  input  logic                core_tx_valid,
  output logic                core_tx_ready,
  output logic [DEPTH_LOG2:0] rx_level,
  output logic [DEPTH_LOG2:0] tx_level,
  output logic [CNT_W-1:0]    drop_cnt
);

  logic              run_q;
  logic              mode_q;

  logic              rx_full;
  logic              rx_empty;
  logic              rx_push;
  logic              rx_pop;
  logic [DATA_W-1:0] rx_head;

  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;
  logic [DATA_W-1:0] tx_head;
  logic [DATA_W-1:0] tx_wdata;

  logic              rx_take;
  logic              drop_hit;
  logic              move;
  logic              core_rx_pop;
  logic              core_tx_push;

  // run_q holds all ready outputs low while reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      mode_q <= mode;
    end
  end

  assign usb_rx_ready = run_q && !flush &&
                        (OVERFLOW_DROP ? 1'b1 : !rx_full);
  assign rx_take      = usb_rx_valid && usb_rx_ready;
  assign rx_push      = rx_take && !rx_full;
  assign drop_hit     = OVERFLOW_DROP && rx_take && rx_full;

  assign move         = run_q && !flush && !mode_q &&
                        !rx_empty && !tx_full;

  assign core_rx_valid = mode_q && !rx_empty && !flush;
  assign core_rx_data  = core_rx_valid ? rx_head : '0;
  assign core_rx_pop   = core_rx_valid && core_rx_ready;
  assign rx_pop        = move || core_rx_pop;

  assign core_tx_ready = run_q && !flush && mode_q && !tx_full;
  assign core_tx_push  = core_tx_valid && core_tx_ready;
  assign tx_push       = move || core_tx_push;
  assign tx_wdata      = mode_q ? core_tx_data : rx_head;

  assign usb_tx_valid  = !tx_empty && !flush;
  assign usb_tx_data   = usb_tx_valid ? tx_head : '0;
  assign tx_pop        = usb_tx_valid && usb_tx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= '0;
    end else if (drop_hit && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  usb_uart_stream_bridge_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (rx_push),
    .wdata   (usb_rx_data),
    .pop     (rx_pop),
    .rdata   (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  usb_uart_stream_bridge_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (tx_push),
    .wdata   (tx_wdata),
    .pop     (tx_pop),
    .rdata   (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

endmodule

// File: tb/tb_usb_uart_stream_bridge.sv
// Directed bench for usb_uart_stream_bridge: loopback, bridge,
// backpressure, drop mode, flush, mode switch and async reset.

module tb_usb_uart_stream_bridge;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mode;
  logic       flush;
  logic [7:0] usb_rx_data;
  logic       usb_rx_valid;
  logic       usb_rx_ready;
  logic [7:0] usb_tx_data;
  logic       usb_tx_valid;
  logic       usb_tx_ready;
  logic [7:0] core_rx_data;
  logic       core_rx_valid;
  logic       core_rx_ready;
  logic [7:0] core_tx_data;
  logic       core_tx_valid;
  logic       core_tx_ready;
  logic [4:0] rx_level;
  logic [4:0] tx_level;
  logic [7:0] drop_cnt;

  logic       d_mode;
  logic       d_flush;
  logic [7:0] d_usb_rx_data;
  logic       d_usb_rx_valid;
  logic       d_usb_rx_ready;
  logic [7:0] d_usb_tx_data;
  logic       d_usb_tx_valid;
  logic [7:0] d_core_rx_data;
  logic       d_core_rx_valid;
  logic       d_core_rx_ready;
  logic       d_core_tx_ready;
  logic [4:0] d_rx_level;
  logic [4:0] d_tx_level;
  logic [7:0] d_drop_cnt;

  always #5 clk = ~clk;

  usb_uart_stream_bridge #(
    .DATA_W(8), .DEPTH_LOG2(4), .OVERFLOW_DROP(1'b0), .CNT_W(8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mode          (mode),
    .flush         (flush),
    .usb_rx_data   (usb_rx_data),
    .usb_rx_valid  (usb_rx_valid),
    .usb_rx_ready  (usb_rx_ready),
    .usb_tx_data   (usb_tx_data),
    .usb_tx_valid  (usb_tx_valid),
    .usb_tx_ready  (usb_tx_ready),
    .core_rx_data  (core_rx_data),
    .core_rx_valid (core_rx_valid),
    .core_rx_ready (core_rx_ready),
    .core_tx_data  (core_tx_data),
    .core_tx_valid (core_tx_valid),
    .core_tx_ready (core_tx_ready),
    .rx_level      (rx_level),
    .tx_level      (tx_level),
    .drop_cnt      (drop_cnt)
  );

  usb_uart_stream_bridge #(
    .DATA_W(8), .DEPTH_LOG2(4), .OVERFLOW_DROP(1'b1), .CNT_W(8)
  ) dut_d (
    .clk           (clk),
    .reset_n       (reset_n),
    .mode          (d_mode),
    .flush         (d_flush),
    .usb_rx_data   (d_usb_rx_data),
    .usb_rx_valid  (d_usb_rx_valid),
    .usb_rx_ready  (d_usb_rx_ready),
    .usb_tx_data   (d_usb_tx_data),
    .usb_tx_valid  (d_usb_tx_valid),
    .usb_tx_ready  (1'b0),
    .core_rx_data  (d_core_rx_data),
    .core_rx_valid (d_core_rx_valid),
    .core_rx_ready (d_core_rx_ready),
    .core_tx_data  (8'h00),
    .core_tx_valid (1'b0),
    .core_tx_ready (d_core_tx_ready),
    .rx_level      (d_rx_level),
    .tx_level      (d_tx_level),
    .drop_cnt      (d_drop_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] rx_q[$];
  logic [7:0] ctx_q[$];
  logic [7:0] got_tx[$];
  logic [7:0] got_core[$];
  int         tx_rdy_mode;
  int         cyc_n;
  int         n_acc;
  int         first_acc;
  int         first_tx;

  task automatic clear_log();
    got_tx.delete();
    got_core.delete();
    n_acc     = 0;
    first_acc = -1;
    first_tx  = -1;
    cyc_n     = 0;
  endtask

  // One cycle: drive at edge+1, sample at edge+3, consume at next edge.
  task automatic cyc();
    usb_rx_valid  = (rx_q.size() > 0);
    usb_rx_data   = usb_rx_valid ? rx_q[0] : 8'h00;
    core_tx_valid = (ctx_q.size() > 0);
    core_tx_data  = core_tx_valid ? ctx_q[0] : 8'h00;
    case (tx_rdy_mode)
      0:       usb_tx_ready = 1'b1;
      1:       usb_tx_ready = cyc_n[0];
      default: usb_tx_ready = 1'b0;
    endcase
    #2;
    if (usb_rx_valid && usb_rx_ready) begin
      void'(rx_q.pop_front());
      n_acc++;
      if (first_acc < 0) first_acc = cyc_n;
    end
    if (core_tx_valid && core_tx_ready) void'(ctx_q.pop_front());
    if (usb_tx_valid && usb_tx_ready) begin
      got_tx.push_back(usb_tx_data);
      if (first_tx < 0) first_tx = cyc_n;
    end
    if (core_rx_valid && core_rx_ready) got_core.push_back(core_rx_data);
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    reset_n = 1'b0;
    mode = 1'b0; flush = 1'b0;
    usb_rx_data = 8'h00; usb_rx_valid = 1'b0; usb_tx_ready = 1'b0;
    core_rx_ready = 1'b0; core_tx_data = 8'h00; core_tx_valid = 1'b0;
    d_mode = 1'b1; d_flush = 1'b0; d_usb_rx_data = 8'h00;
    d_usb_rx_valid = 1'b0; d_core_rx_ready = 1'b0;
    tx_rdy_mode = 0;
    clear_log();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", usb_rx_ready, 0);
    chk("rst_tx_valid", usb_tx_valid, 0);
    chk("rst_tx_data", usb_tx_data, 0);
    chk("rst_d_rx_ready", d_usb_rx_ready, 0);
    chk("rst_levels", {rx_level, tx_level, drop_cnt}, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rel_rx_ready", usb_rx_ready, 1);
    chk("rel_d_rx_ready", d_usb_rx_ready, 1);

    // Loopback latency and ordering
    rx_q = '{8'h41, 8'h42, 8'h43};
    run(10);
    chk("lb_latency", first_tx - first_acc, 2);
    chk("lb_count", got_tx.size(), 3);
    for (int i = 0; i < 3; i++) chk("lb_data", got_tx[i], 8'h41 + i);
    chk("lb_no_core", got_core.size(), 0);

    // Bridge RX backpressure then drain
    mode = 1'b1;
    run(2);
    clear_log();
    core_rx_ready = 1'b0;
    for (int i = 0; i < 20; i++) rx_q.push_back(8'h10 + i[7:0]);
    run(25);
    #1;
    chk("br_acc16", n_acc, 16);
    chk("br_rx_ready0", usb_rx_ready, 0);
    chk("br_rx_level16", rx_level, 16);
    core_rx_ready = 1'b1;
    run(40);
    chk("br_core_count", got_core.size(), 20);
    for (int i = 0; i < 20; i++) chk("br_core_data", got_core[i], 8'h10 + i);
    chk("br_no_loop", got_tx.size(), 0);
    chk("br_rx_level0", rx_level, 0);

    // Core TX with toggling usb_tx_ready
    clear_log();
    tx_rdy_mode = 1;
    for (int i = 0; i < 16; i++) ctx_q.push_back(i[7:0]);
    run(60);
    chk("ctx_count", got_tx.size(), 16);
    for (int i = 0; i < 16; i++) chk("ctx_data", got_tx[i], i);
    chk("ctx_tx_level0", tx_level, 0);

    // Flush with a word arriving
    clear_log();
    core_rx_ready = 1'b0;
    tx_rdy_mode = 2;
    rx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    ctx_q = '{8'h0A, 8'h0B, 8'h0C};
    run(8);
    chk("fl_rx_level5", rx_level, 5);
    chk("fl_tx_level3", tx_level, 3);
    flush = 1'b1;
    usb_rx_valid = 1'b1;
    usb_rx_data = 8'hAA;
    #2;
    chk("fl_rx_ready0", usb_rx_ready, 0);
    chk("fl_ctx_ready0", core_tx_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    usb_rx_valid = 1'b0;
    #1;
    chk("fl_levels0", {rx_level, tx_level}, 0);
    chk("fl_drop0", drop_cnt, 0);
    chk("fl_valids0", {core_rx_valid, usb_tx_valid}, 0);

    // Drop-on-overflow instance
    for (int i = 0; i < 316; i++) begin
      d_usb_rx_data = i[7:0];
      d_usb_rx_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i == 15) chk("dr_full16", d_rx_level, 16);
      if (i == 25) chk("dr_cnt10", d_drop_cnt, 10);
    end
    #1;
    chk("dr_cnt_sat", d_drop_cnt, 255);
    chk("dr_ready_hi", d_usb_rx_ready, 1);
    chk("dr_level16", d_rx_level, 16);
    d_usb_rx_valid = 1'b0;
    d_core_rx_ready = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("dr_data", {d_core_rx_valid, d_core_rx_data}, {1'b1, i[7:0]});
      @(posedge clk);
      #2;
    end
    chk("dr_empty", d_core_rx_valid, 0);
    d_core_rx_ready = 1'b0;
    d_usb_rx_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("dr_cnt_again", d_drop_cnt, 255);
    d_flush = 1'b1;
    #1;
    chk("dr_fl_ready0", d_usb_rx_ready, 0);
    @(posedge clk);
    #1;
    d_flush = 1'b0;
    d_usb_rx_valid = 1'b0;
    #1;
    chk("dr_fl_cnt0", d_drop_cnt, 0);
    chk("dr_fl_level0", d_rx_level, 0);

    // Mode switch during a loopback stream
    clear_log();
    mode = 1'b0;
    run(2);
    clear_log();
    core_rx_ready = 1'b1;
    tx_rdy_mode = 0;
    for (int i = 0; i < 16; i++) rx_q.push_back(8'h60 + i[7:0]);
    run(6);
    mode = 1'b1;
    run(30);
    chk("sw_tx_some", got_tx.size() > 0, 1);
    chk("sw_core_some", got_core.size() > 0, 1);
    chk("sw_total", got_tx.size() + got_core.size(), 16);
    foreach (got_core[i]) got_tx.push_back(got_core[i]);
    for (int i = 0; i < 16; i++) chk("sw_order", got_tx[i], 8'h60 + i);

    // Async reset mid-stream
    mode = 1'b0;
    run(2);
    for (int i = 0; i < 8; i++) rx_q.push_back(8'h80 + i[7:0]);
    run(3);
    usb_rx_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_readys", {usb_rx_ready, core_tx_ready}, 0);
    chk("ar_valids", {usb_tx_valid, core_rx_valid}, 0);
    chk("ar_data", {usb_tx_data, core_rx_data}, 0);
    chk("ar_levels", {rx_level, tx_level, drop_cnt}, 0);
    rx_q.delete();
    usb_rx_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("ar_post_levels", {rx_level, tx_level}, 0);
    chk("ar_post_valid", usb_tx_valid, 0);
    chk("ar_post_ready", usb_rx_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
